// File: rtl/rvvi_flow_ctrl.sv
// Credit-window flow controller for the RVVI Ethernet trace path: numbers outgoing
// frames, tracks cumulative host acks, holds off the packetizer and backs off delay.
module rvvi_flow_ctrl #(
  parameter int          FRAME_COUNT_WIDTH = 64,
  parameter int          WINDOW            = 4,
  parameter logic [31:0] ACK_TIMEOUT       = 32'd1000000,
  parameter logic [31:0] DEFAULT_DELAY     = 32'd2,
  parameter logic [31:0] MAX_DELAY         = 32'd65536
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         FrameSent,
  input  logic                         AckValid,
  input  logic [FRAME_COUNT_WIDTH-1:0] AckFrame,
  input  logic                         CfgValid,
  input  logic [31:0]                  CfgDelay,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic [31:0]                  InnerPktDelay,
  output logic                         HoldOff,
  output logic [3:0]                   Outstanding,
  output logic                         Timeout,
  output logic                         Overflow,
  output logic                         BadAck
);

  localparam logic [FRAME_COUNT_WIDTH-1:0] LP_ONE    = FRAME_COUNT_WIDTH'(1);
  localparam logic [FRAME_COUNT_WIDTH-1:0] LP_ZERO   = '0;
  localparam logic [FRAME_COUNT_WIDTH-1:0] LP_WINDOW = FRAME_COUNT_WIDTH'(WINDOW);
  localparam logic [FRAME_COUNT_WIDTH-1:0] LP_LIMIT  = FRAME_COUNT_WIDTH'(WINDOW + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_FULL, ST_STALLED} state_t;

  state_t                         r_state;
  state_t                         w_nextState;
  logic [FRAME_COUNT_WIDTH-1:0]   r_frameCount;
  logic [FRAME_COUNT_WIDTH-1:0]   r_ackedBase;
  logic [FRAME_COUNT_WIDTH-1:0]   w_pending;
  logic [FRAME_COUNT_WIDTH-1:0]   w_ackDist;
  logic [FRAME_COUNT_WIDTH-1:0]   w_nextFrame;
  logic [FRAME_COUNT_WIDTH-1:0]   w_nextBase;
  logic [FRAME_COUNT_WIDTH-1:0]   w_nextPending;
  logic [31:0]                    r_timer;
  logic [31:0]                    r_delay;
  logic [31:0]                    w_nextDelay;
  logic [32:0]                    w_doubled;
  logic                           r_holdOff;
  logic [3:0]                     r_outstanding;
  logic                           r_timeout;
  logic                           r_overflow;
  logic                           r_badAck;
  logic                           w_ackOk;
  logic                           w_drop;
  logic                           w_active;
  logic                           w_expire;

  // All window arithmetic is modular so acceptance survives FrameCount wrap.
  always_comb begin
    w_pending     = r_frameCount - r_ackedBase;
    w_ackDist     = AckFrame - r_ackedBase;
    w_ackOk       = AckValid && (w_ackDist < w_pending);
    w_drop        = FrameSent && !w_ackOk && (w_pending == LP_LIMIT);
    w_nextFrame   = FrameSent ? r_frameCount + LP_ONE : r_frameCount;
    w_nextBase    = w_ackOk ? AckFrame + LP_ONE
                  : (w_drop ? r_ackedBase + LP_ONE : r_ackedBase);
    w_nextPending = w_nextFrame - w_nextBase;
    w_active      = (r_state == ST_OPEN) || (r_state == ST_FULL);
    w_expire      = w_active && (r_timer == ACK_TIMEOUT - 32'd1) && !w_ackOk;
    w_doubled     = {r_delay, 1'b0};

    if (w_expire || ((r_state == ST_STALLED) && !w_ackOk)) begin
      w_nextState = ST_STALLED;
    end else if (w_nextPending == LP_ZERO) begin
      w_nextState = ST_IDLE;
    end else if (w_nextPending < LP_WINDOW) begin
      w_nextState = ST_OPEN;
    end else begin
      w_nextState = ST_FULL;
    end

    // A config write overrides the backoff step taken in the same cycle.
    if (CfgValid) begin
      w_nextDelay = CfgDelay;
    end else if (w_expire) begin
      if (r_delay == 32'd0) begin
        w_nextDelay = 32'd1;
      end else if (w_doubled > {1'b0, MAX_DELAY}) begin
        w_nextDelay = MAX_DELAY;
      end else begin
        w_nextDelay = w_doubled[31:0];
      end
    end else begin
      w_nextDelay = r_delay;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_frameCount  <= '0;
      r_ackedBase   <= '0;
      r_timer       <= '0;
      r_delay       <= DEFAULT_DELAY;
      r_holdOff     <= 1'b0;
      r_outstanding <= '0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_badAck      <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_frameCount  <= w_nextFrame;
      r_ackedBase   <= w_nextBase;
      r_timer       <= (w_active && !w_ackOk && !w_expire && (w_nextState != ST_IDLE))
                     ? r_timer + 32'd1 : 32'd0;
      r_delay       <= w_nextDelay;
      r_holdOff     <= (w_nextState == ST_FULL) || (w_nextState == ST_STALLED);
      r_outstanding <= w_nextPending[3:0];
      r_timeout     <= w_expire ? 1'b1 : (CfgValid ? 1'b0 : r_timeout);
      r_overflow    <= w_drop ? 1'b1 : (CfgValid ? 1'b0 : r_overflow);
      r_badAck      <= AckValid && !w_ackOk;
    end
  end

  assign FrameCount    = r_frameCount;
  assign InnerPktDelay = r_delay;
  assign HoldOff       = r_holdOff;
  assign Outstanding   = r_outstanding;
  assign Timeout       = r_timeout;
  assign Overflow      = r_overflow;
  assign BadAck        = r_badAck;

endmodule
